// File: rtl/risc_trace_buffer.sv
// rtl/risc_trace_buffer.sv - retire-trace capture buffer with cycle stamping, halt freeze and pop port
// Stores {cycle, pc, inst} per retired instruction in a circular register array.
module risc_trace_buffer #(
  parameter  int DATA_W  = 32,
  parameter  int DEPTH   = 16,
  parameter  int CYCLE_W = 32,
  parameter  int MODE    = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               ret_valid_i,
  input  logic [DATA_W-1:0]  ret_inst_i,
  input  logic [DATA_W-1:0]  ret_pc_i,
  input  logic               halt_i,
  input  logic               rd_req_i,
  output logic               rd_valid_o,
  output logic [DATA_W-1:0]  rd_inst_o,
  output logic [DATA_W-1:0]  rd_pc_o,
  output logic [CYCLE_W-1:0] rd_cycle_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               overflow_o,
  output logic               halted_o,
  output logic [CYCLE_W-1:0] cycle_cnt_o
);

  localparam int  AW      = $clog2(DEPTH);
  localparam int  ENTRY_W = CYCLE_W + 2 * DATA_W;
  localparam bit  WRAP    = (MODE == 0);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               halted_q, halted_d;
  logic               overflow_q, overflow_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_inst_q, rd_inst_d;
  logic [DATA_W-1:0]  rd_pc_q, rd_pc_d;
  logic [CYCLE_W-1:0] rd_cycle_q, rd_cycle_d;

  logic active, wr_req, pop, is_full, write, overwrite, drop;
  logic [ENTRY_W-1:0] head;

  assign active    = en_i & ~halted_q & ~clear_i;
  assign wr_req    = active & ret_valid_i;
  assign pop       = rd_req_i & (count_q != '0) & ~clear_i;
  assign is_full   = (count_q == CNT_W'(DEPTH));
  // A full buffer without a simultaneous pop either replaces its oldest entry or refuses the new one.
  assign write     = wr_req & (~is_full | pop | WRAP);
  assign overwrite = write & is_full & ~pop;
  assign drop      = wr_req & is_full & ~pop;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cycle_d    = cycle_q;
    halted_d   = halted_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_inst_d  = rd_inst_q;
    rd_pc_d    = rd_pc_q;
    rd_cycle_d = rd_cycle_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      cycle_d    = '0;
      halted_d   = 1'b0;
      overflow_d = 1'b0;
      rd_inst_d  = '0;
      rd_pc_d    = '0;
      rd_cycle_d = '0;
    end else begin
      if (write) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop || overwrite) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(write & ~overwrite) - CNT_W'(pop);
      if (active && cycle_q != {CYCLE_W{1'b1}}) cycle_d = cycle_q + CYCLE_W'(1);
      halted_d   = halted_q | halt_i;
      overflow_d = overflow_q | drop;
      if (pop) begin
        rd_valid_d = 1'b1;
        {rd_cycle_d, rd_pc_d, rd_inst_d} = head;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_inst_q  <= '0;
      rd_pc_q    <= '0;
      rd_cycle_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_inst_q  <= rd_inst_d;
      rd_pc_q    <= rd_pc_d;
      rd_cycle_q <= rd_cycle_d;
    end
  end

  // Contents need no reset: count gates every read, so stale slots are never exposed.
  always_ff @(posedge clk_i) begin
    if (write) mem_q[wr_ptr_q] <= {cycle_q, ret_pc_i, ret_inst_i};
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_inst_o   = rd_inst_q;
  assign rd_pc_o     = rd_pc_q;
  assign rd_cycle_o  = rd_cycle_q;
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = is_full;
  assign overflow_o  = overflow_q;
  assign halted_o    = halted_q;
  assign cycle_cnt_o = cycle_q;

endmodule

// File: tb/tb_risc_trace_buffer.sv
// tb/tb_risc_trace_buffer.sv - self-checking bench for risc_trace_buffer (wrap and stop modes side by side)
module tb_risc_trace_buffer;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [CW-1:0] cyc;
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst, en, clear, ret_valid, halt, rd_req;
  logic [DW-1:0] ret_inst, ret_pc;

  logic          rd_valid_w  [2];
  logic [DW-1:0] rd_inst_w   [2];
  logic [DW-1:0] rd_pc_w     [2];
  logic [CW-1:0] rd_cycle_w  [2];
  logic [2:0]    count_w     [2];
  logic          empty_w     [2];
  logic          full_w      [2];
  logic          overflow_w  [2];
  logic          halted_w    [2];
  logic [CW-1:0] cycle_cnt_w [2];

  int n_assert = 0;
  int n_fail   = 0;

  entry_t mq0[$];
  entry_t mq1[$];
  int     mcyc;
  bit     mhalt;
  bit     movf [2];
  bit     mrv  [2];
  entry_t mrd  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    risc_trace_buffer #(.DATA_W(DW), .DEPTH(DP), .CYCLE_W(CW), .MODE(g)) u_dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
      .ret_valid_i(ret_valid), .ret_inst_i(ret_inst), .ret_pc_i(ret_pc),
      .halt_i(halt), .rd_req_i(rd_req),
      .rd_valid_o(rd_valid_w[g]), .rd_inst_o(rd_inst_w[g]), .rd_pc_o(rd_pc_w[g]),
      .rd_cycle_o(rd_cycle_w[g]), .count_o(count_w[g]), .empty_o(empty_w[g]),
      .full_o(full_w[g]), .overflow_o(overflow_w[g]), .halted_o(halted_w[g]),
      .cycle_cnt_o(cycle_cnt_w[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mcyc  = 0;
    mhalt = 0;
    for (int m = 0; m < 2; m++) begin
      movf[m] = 0;
      mrv[m]  = 0;
    end
  endtask

  // Reference: a bounded queue per mode; pops come off the front, retires push on the back.
  task automatic model_edge();
    bit     act;
    entry_t e;
    if (clear) begin
      model_reset();
    end else begin
      act = en && !mhalt;
      e   = '{cyc: CW'(mcyc), pc: ret_pc, inst: ret_inst};
      for (int m = 0; m < 2; m++) begin
        entry_t q[$];
        if (m == 0) q = mq0; else q = mq1;
        mrv[m] = 0;
        if (rd_req && q.size() > 0) begin
          mrd[m] = q.pop_front();
          mrv[m] = 1;
        end
        if (act && ret_valid) begin
          if (q.size() < DP) q.push_back(e);
          else begin
            movf[m] = 1;
            if (m == 0) begin
              void'(q.pop_front());
              q.push_back(e);
            end
          end
        end
        if (m == 0) mq0 = q; else mq1 = q;
      end
      if (act && mcyc < (1 << CW) - 1) mcyc++;
      if (halt) mhalt = 1;
    end
  endtask

  task automatic check_all();
    int sz;
    for (int m = 0; m < 2; m++) begin
      sz = (m == 0) ? mq0.size() : mq1.size();
      chk($sformatf("count%0d", m), count_w[m], sz);
      chk($sformatf("empty%0d", m), empty_w[m], sz == 0);
      chk($sformatf("full%0d", m), full_w[m], sz == DP);
      chk($sformatf("overflow%0d", m), overflow_w[m], movf[m]);
      chk($sformatf("halted%0d", m), halted_w[m], mhalt);
      chk($sformatf("cycle_cnt%0d", m), cycle_cnt_w[m], mcyc);
      chk($sformatf("rd_valid%0d", m), rd_valid_w[m], mrv[m]);
      if (mrv[m]) begin
        chk($sformatf("rd_cycle%0d", m), rd_cycle_w[m], mrd[m].cyc);
        chk($sformatf("rd_pc%0d", m), rd_pc_w[m], mrd[m].pc);
        chk($sformatf("rd_inst%0d", m), rd_inst_w[m], mrd[m].inst);
      end
    end
  endtask

  task automatic step(input bit e, input bit rv, input logic [DW-1:0] pc, input bit h,
                      input bit rq, input bit cl);
    en = e; ret_valid = rv; ret_pc = pc; ret_inst = $urandom; halt = h; rd_req = rq; clear = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_rd_valid"}, rd_valid_w[m], 0);
      chk({tag, "_rd_pc"}, rd_pc_w[m], 0);
      chk({tag, "_rd_inst"}, rd_inst_w[m], 0);
      chk({tag, "_rd_cycle"}, rd_cycle_w[m], 0);
      chk({tag, "_empty"}, empty_w[m], 1);
      chk({tag, "_count"}, count_w[m], 0);
      chk({tag, "_cyc"}, cycle_cnt_w[m], 0);
      chk({tag, "_flags"}, {full_w[m], overflow_w[m], halted_w[m]}, 0);
    end
  endtask

  initial begin
    rst = 1; en = 0; clear = 0; ret_valid = 0; halt = 0; rd_req = 0; ret_inst = 0; ret_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // 1: reset mid-drain, then idle counting
    for (int i = 0; i < 3; i++) step(1, 1, 32'(i * 4), 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    rst = 1;
    #1;
    model_reset();
    check_zero("t1_rst");
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    chk("t1_cyc5", cycle_cnt_w[0], 5);

    // 2: capture at cycles 2..4, drain in order
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'(i * 4), 0, 0, 0);
    chk("t2_count", count_w[0], 3);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("t2_rv", rd_valid_w[0], 1);
      chk("t2_cyc", rd_cycle_w[0], 2 + k);
      chk("t2_pc", rd_pc_w[0], 4 * k);
    end
    chk("t2_empty", empty_w[0], 1);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_pop_empty", rd_valid_w[0], 0);

    // 3/4: six retires into four slots
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 32'(i * 4), 0, 0, 0);
    chk("t34_count", {count_w[1], count_w[0]}, {3'd4, 3'd4});
    chk("t34_ovf", {overflow_w[1], overflow_w[0]}, 2'b11);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("t3_wrap_pc", rd_pc_w[0], 8 + 4 * k);
      chk("t4_stop_pc", rd_pc_w[1], 4 * k);
    end

    // 5: full buffer, retire and pop together
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 32'(i * 4), 0, 0, 0);
    step(1, 1, 32'h100, 0, 1, 0);
    chk("t5_count", {count_w[1], count_w[0]}, {3'd4, 3'd4});
    chk("t5_ovf", {overflow_w[1], overflow_w[0]}, 2'b00);
    chk("t5_oldest", {rd_pc_w[1], rd_pc_w[0]}, 64'd0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0);
    chk("t5_last", rd_pc_w[0], 32'h100);

    // 6: halt freezes capture and counting; clear restarts
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h40, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h80, 0, 0, 0);
    chk("t6_cyc", cycle_cnt_w[0], 11);
    chk("t6_count", count_w[0], 1);
    step(1, 0, 0, 0, 1, 0);
    chk("t6_ts", rd_cycle_w[0], 10);
    chk("t6_pc", rd_pc_w[0], 32'h40);
    step(0, 0, 0, 0, 0, 1);
    check_zero("t6_clr");
    step(1, 0, 0, 0, 0, 0);
    chk("t6_resume", cycle_cnt_w[0], 1);

    // Counter saturation
    for (int i = 0; i < 260; i++) step(1, 0, 0, 0, 0, 0);
    chk("sat", cycle_cnt_w[0], 255);

    // Random traffic against the queue model
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1, $urandom,
           $urandom_range(99, 0) < 2, $urandom_range(9, 0) < 4, $urandom_range(99, 0) < 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
